// File: rtl/disp_pkg.sv
// Shared types and constants for the dash display scan controller.
// Holds the RGB pixel type, default panel timing (800x480) and the
// colour-bar table used when DISP_TEST_PATTERN_EN is defined.
package disp_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 21;
  localparam int DEF_N_LAYERS = 4;

  localparam rgb_t COLOR_BLACK = rgb_t'(24'h000000);

  // Eight vertical bars, left to right: white, yellow, cyan, green,
  // magenta, red, blue, black.
  function automatic rgb_t barColor(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = rgb_t'(24'hFFFFFF);
      3'd1:    c = rgb_t'(24'hFFFF00);
      3'd2:    c = rgb_t'(24'h00FFFF);
      3'd3:    c = rgb_t'(24'h00FF00);
      3'd4:    c = rgb_t'(24'hFF00FF);
      3'd5:    c = rgb_t'(24'hFF0000);
      3'd6:    c = rgb_t'(24'h0000FF);
      default: c = COLOR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bundle between the scan controller, the layer renderers, the register
// block and the panel pins. The master modport is the controller side.
// Optional macro DISP_TEST_PATTERN_EN adds the test_mode input.
interface disp_scan_ctrl_if #(
  parameter int N_LAYERS = 4
);

  logic                     enable;
  logic [N_LAYERS-1:0]      layer_en;
  logic [N_LAYERS-1:0]      layer_draw;
  logic [N_LAYERS-1:0][23:0] layer_color;
`ifdef DISP_TEST_PATTERN_EN
  logic                     test_mode;
`endif
  logic [9:0]               disp_x;
  logic [9:0]               disp_y;
  logic                     hsync;
  logic                     vsync;
  logic                     de;
  logic [7:0]               red;
  logic [7:0]               green;
  logic [7:0]               blue;
  logic                     frame_start;
  logic                     status;

  modport master (
`ifdef DISP_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  enable, layer_en, layer_draw, layer_color,
    output disp_x, disp_y, hsync, vsync, de, red, green, blue,
           frame_start, status
  );

  modport slave (
`ifdef DISP_TEST_PATTERN_EN
    output test_mode,
`endif
    output enable, layer_en, layer_draw, layer_color,
    input  disp_x, disp_y, hsync, vsync, de, red, green, blue,
           frame_start, status
  );

endinterface

// File: rtl/disp_timing_gen.sv
// Raster counters and region decode for the scan controller.
// Owns h/v counters, active/sync flags and the frame-origin flag; the
// scan position it exports is zero outside the visible area.
module disp_timing_gen
  import disp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       active_o,
  output logic       hSync_o,
  output logic       vSync_o,
  output logic       origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;
  logic        hActive, vActive;

  // Advance the raster; a disabled scan parks at the frame origin.
  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (!enable_i) begin
      hCnt_d = '0;
      vCnt_d = '0;
    end else if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? 11'd0 : vCnt_q + 11'd1;
    end else begin
      hCnt_d = hCnt_q + 11'd1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  assign hActive  = (hCnt_q < H_ACT_END);
  assign vActive  = (vCnt_q < V_ACT_END);
  assign active_o = hActive & vActive;
  assign hSync_o  = (hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END);
  assign vSync_o  = (vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END);
  assign origin_o = (hCnt_q == 11'd0) && (vCnt_q == 11'd0);

  // Reset is sampled at the edge, so gate here to read 0 while it is held.
  assign x_o = (rst_ni && active_o) ? hCnt_q[9:0] : 10'd0;
  assign y_o = (rst_ni && active_o) ? vCnt_q[9:0] : 10'd0;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan-timing controller and layer compositor for the dash display.
// Picks the highest-priority enabled layer per pixel and registers RGB,
// syncs and de together so the panel sees them aligned.
// Optional macro DISP_TEST_PATTERN_EN adds a colour-bar test mode.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int N_LAYERS = DEF_N_LAYERS
) (
  input logic               Clk,
  input logic               Reset_n,
  disp_scan_ctrl_if.master  bus
);

  logic active, hSync, vSync, origin;
  rgb_t winner, pixel;
  rgb_t rgb_q, rgb_d;
  logic de_q, de_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frameStart_q, frameStart_d;
  logic status_q;

  disp_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .enable_i (bus.enable),
    .x_o      (bus.disp_x),
    .y_o      (bus.disp_y),
    .active_o (active),
    .hSync_o  (hSync),
    .vSync_o  (vSync),
    .origin_o (origin)
  );

  // Fixed priority: scanning downward leaves the lowest claiming index.
  always_comb begin
    winner = COLOR_BLACK;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_draw[i] && bus.layer_en[i]) begin
        winner = rgb_t'(bus.layer_color[i]);
      end
    end
  end

`ifdef DISP_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  logic [9:0] barIdx;

  // Colour bars replace the composited layers while test_mode is set.
  always_comb begin
    barIdx = bus.disp_x / 10'(BAR_W);
    if (barIdx > 10'd7) begin
      barIdx = 10'd7;
    end
    pixel = bus.test_mode ? barColor(barIdx[2:0]) : winner;
  end
`else
  assign pixel = winner;
`endif

  // Next output word; everything is blanked while the scan is disabled.
  always_comb begin
    rgb_d        = COLOR_BLACK;
    de_d         = 1'b0;
    hsync_d      = 1'b0;
    vsync_d      = 1'b0;
    frameStart_d = 1'b0;
    if (bus.enable) begin
      de_d         = active;
      rgb_d        = active ? pixel : COLOR_BLACK;
      hsync_d      = hSync;
      vsync_d      = vSync;
      frameStart_d = origin;
    end
  end

  // Output register stage: one clock of latency for all panel signals.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rgb_q        <= COLOR_BLACK;
      de_q         <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frameStart_q <= 1'b0;
      status_q     <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      de_q         <= de_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frameStart_q <= frameStart_d;
      status_q     <= bus.enable;
    end
  end

  assign bus.red         = rgb_q.r;
  assign bus.green       = rgb_q.g;
  assign bus.blue        = rgb_q.b;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = frameStart_q;
  assign bus.status      = status_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl on a tiny 8x4 raster.
// The reference tracks a single pixel index since the frame origin and
// derives position, regions and colour from it arithmetically.
// Honours DISP_TEST_PATTERN_EN when the design is built with it.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int HA = 8, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int NL = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        st;
  } exp_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;
  logic [23:0] barTab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  disp_scan_ctrl_if #(.N_LAYERS(NL)) bus ();

  disp_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .N_LAYERS(NL)
  ) dut (
    .Clk     (clk),
    .Reset_n (rstN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [23:0] act,
                             input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check stage-0 position, drive inputs, queue expected output.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [NL-1:0] lEn, input logic [NL-1:0] draw,
                               input logic [NL-1:0][23:0] col, input logic tm);
    int h, v;
    logic act;
    exp_t e;
    @(negedge clk);
    h   = pos % HT;
    v   = pos / HT;
    act = (h < HA) && (v < VA);
    checkOutput("disp_x", {14'd0, bus.disp_x}, (rstN && act) ? 24'(h) : 24'd0);
    checkOutput("disp_y", {14'd0, bus.disp_y}, (rstN && act) ? 24'(v) : 24'd0);
    rstN           = rst;
    bus.enable     = en;
    bus.layer_en   = lEn;
    bus.layer_draw = draw;
    bus.layer_color = col;
`ifdef DISP_TEST_PATTERN_EN
    bus.test_mode  = tm;
`endif
    e = '{rgb: 24'd0, de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, st: 1'b0};
    if (rst && en) begin
      e.st = 1'b1;
      e.de = act;
      e.hs = (h >= HA + HF) && (h < HA + HF + HS);
      e.vs = (v >= VA + VF) && (v < VA + VF + VS);
      e.fs = (pos == 0);
      if (act) begin
        for (int i = 0; i < NL; i++) begin
          if (draw[i] && lEn[i]) begin
            e.rgb = col[i];
            break;
          end
        end
`ifdef DISP_TEST_PATTERN_EN
        if (tm) e.rgb = barTab[h / (HA / 8)];
`else
        if (tm) e.rgb = e.rgb;
`endif
      end
      pos = (pos + 1) % (HT * VT);
    end else begin
      pos = 0;
    end
    expQ.push_back(e);
  endtask

  // Monitor: compare each registered output word after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("rgb", {bus.red, bus.green, bus.blue}, e.rgb);
        checkOutput("de", {23'd0, bus.de}, {23'd0, e.de});
        checkOutput("hsync", {23'd0, bus.hsync}, {23'd0, e.hs});
        checkOutput("vsync", {23'd0, bus.vsync}, {23'd0, e.vs});
        checkOutput("frame_start", {23'd0, bus.frame_start}, {23'd0, e.fs});
        checkOutput("status", {23'd0, bus.status}, {23'd0, e.st});
      end
    end
  end

  initial begin
    logic [NL-1:0][23:0] col;
    logic [NL-1:0] draw;
    bus.enable      = 1'b0;
    bus.layer_en    = '0;
    bus.layer_draw  = '0;
    bus.layer_color = '0;
`ifdef DISP_TEST_PATTERN_EN
    bus.test_mode   = 1'b0;
`endif
    col = '0;
    repeat (3) applyStimulus(1'b0, 1'b0, '0, '0, col, 1'b0);

    // Two idle frames: timing only, black picture.
    repeat (2 * HT * VT) applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, col, 1'b0);

    // Layers 1 and 3 compete, then layer masks are cleared one by one.
    col[1] = 24'h00FF00;
    col[3] = 24'hFF0000;
    repeat (20) applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1010, col, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 4'b1101, 4'b1010, col, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 4'b0101, 4'b1010, col, 1'b0);

    // Single-pixel claim by layer 0 at (3,2).
    col[0] = 24'h123456;
    repeat (HT * VT) begin
      draw = '0;
      draw[0] = ((pos % HT) == 3) && ((pos / HT) == 2);
      applyStimulus(1'b1, 1'b1, 4'hF, draw, col, 1'b0);
    end

    // Disable for a few clocks, then restart from the origin.
    repeat (4) applyStimulus(1'b1, 1'b0, 4'hF, 4'h0, col, 1'b0);
    repeat (30) applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, col, 1'b0);

    // Reset pulse mid-frame at h=5, v=2.
    while (pos != 2 * HT + 5) applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, col, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'h0, col, 1'b0);
    repeat (HT * VT + 4) applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, col, 1'b0);

    // Randomised layers, masks, occasional disable and reset.
    repeat (1500) begin
      for (int i = 0; i < NL; i++) col[i] = 24'($urandom);
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 39) != 0,
                    4'($urandom), 4'($urandom), col, 1'($urandom));
    end

    // A clean frame of colour bars with random layer activity underneath.
    repeat (HT * VT + 2) begin
      for (int i = 0; i < NL; i++) col[i] = 24'($urandom);
      applyStimulus(1'b1, 1'b1, 4'($urandom), 4'($urandom), col, 1'b1);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
Scan-timing controller and layer compositor for the dash display. Generates the raster scan (disp_x/disp_y) that drives every layer renderer (background, speed, battery and GPS widgets). Arbitrates their draw/color responses by fixed priority into one registered RGB pixel stream with aligned syncs and data-enable. Sits between the layer renderers and the panel pins, beside the host-written register block.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync width (clocks)
H_BP, 88, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 21, vertical back porch (lines)
N_LAYERS, 4, number of competing layers; index 0 is highest priority

Ports:
Clk  input  1  pixel clock
Reset_n  input  1  synchronous active-low reset
enable  input  1  scan run enable, from the register block
layer_en  input  N_LAYERS  per-layer mask, from the register block
layer_draw  input  N_LAYERS  layer i claims the current pixel
layer_color  input  N_LAYERS x 24  layer i colour {R[23:16],G[15:8],B[7:0]}
disp_x  output  10  current scan column
disp_y  output  10  current scan row
hsync  output  1  horizontal sync, active high
vsync  output  1  vertical sync, active high
de  output  1  data enable, aligned with RGB
red  output  8  pixel red
green  output  8  pixel green
blue  output  8  pixel blue
frame_start  output  1  one-cycle pulse at h=0, v=0
status  output  1  scan running

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on each h wrap and runs 0..V_TOTAL-1, wrapping to 0.
- Region order per axis: active [0, ACTIVE), front porch, sync, back porch.
- Stage 0 (combinational from counters):
  - disp_x = h_cnt, disp_y = v_cnt while active; both 0 outside the active area.
  - active0 = h active AND v active.
  - Layers answer layer_draw/layer_color combinationally in the same cycle.
- Arbitration: winner = lowest index i with layer_draw[i] & layer_en[i]. With no winner, colour = 24'h000000.
- Stage 1 (registered, latency 1):
  - RGB = winner colour when active0, else 0.
  - de = active0.
  - hsync = h_cnt in sync region; vsync = v_cnt in sync region.
  - All outputs change only on Clk rising edge. Syncs are delayed with RGB so panel alignment holds.
- frame_start: registered, high for exactly 1 cycle when h_cnt=0, v_cnt=0 and enable=1; aligned with the first de of the frame.
- enable=0:
  - Counters are forced to 0 next edge.
  - RGB, de, hsync, vsync, frame_start go 0 next edge.
  - status=0.
- enable 0->1: scan starts at h=0, v=0. frame_start asserts on the first enabled cycle's output (1 cycle after enable rises).
- status = registered enable.
- Reset (Reset_n=0 at edge), including mid-frame: counters=0; red/green/blue/hsync/vsync/de/frame_start/status=0.
  - disp_x/disp_y are combinational and read 0 during reset.
  - Scanning restarts at the frame origin on the first edge with Reset_n=1 and enable=1.
- layer_en changes take effect on the next pixel; no frame-boundary shadowing (the register block handles that).
- Counter widths are 11 bits internally, so H_TOTAL up to 2047 is legal. disp_x/disp_y are truncated to 10 bits, which requires H_ACTIVE, V_ACTIVE ≤ 1024.

Optional Feature:
DISP_TEST_PATTERN_EN
- Defined: adds input test_mode (1 bit). When test_mode=1, arbitration is bypassed and RGB shows 8 vertical colour bars, bar index = disp_x / (H_ACTIVE/8), in order white, yellow, cyan, green, magenta, red, blue, black. Timing, latency and de are unchanged.
- Undefined: no test_mode port; behaviour exactly as above.

Decomposition:
- Shared package disp_pkg:
  - typedef rgb_t (struct, 8-bit r/g/b)
  - default timing constants
  - localparam COLOR_BLACK
  - test-bar colour table
- One sub-module, disp_timing_gen, owns h_cnt/v_cnt, the region decode (active/sync flags) and frame origin. The parent keeps arbitration, the output register stage and the optional pattern.

Test Plan:
- Small timing (H 8/1/2/1, V 4/1/1/1), enable=1 from reset, no layers drawing: de high 8 clocks per line, 4 lines per frame. hsync high 2 clocks starting 9 clocks after line start. Period 12 clocks/line, 7 lines/frame. RGB always 0.
- Layers 1 and 3 draw with 24'h00FF00 and 24'hFF0000, all enabled: output 00FF00. Clear layer_en[1]: next pixel is FF0000. Clear layer_en[3] too: output 000000.
- Layer 0 draws only at disp_x=3, disp_y=2 with 24'h123456: exactly one output pixel red=12/green=34/blue=56, appearing 1 clock after the counters hit (3,2), with de=1.
- frame_start: pulses once per 84 clocks (12x7), coincident with the first de=1 of the frame. Check the pulse follows the enable 0->1 transition by 1 cycle.
- Reset_n low at h=5, v=2 for 1 cycle: all outputs 0 next edge. After release, counting restarts at (0,0) and the next frame_start arrives 1 cycle after release.
- With DISP_TEST_PATTERN_EN, H_ACTIVE=16, test_mode=1: pixels 0-1 are FFFFFF, 2-3 FFFF00, …, 14-15 000000, regardless of layer_draw.
